datapath_mc: RTL and testbench
==============================

Name: datapath_mc

Overview:
Parametrised multi-cycle datapath: 2-read/1-write register file, full ALU with real subtraction flags, and an iterative shift-add multiplier with stall handshake to the controller.
Sits between the controller, which supplies decoded fields and control, and data memory or cache, which receives address and write data.
Successor to the single-cycle datapath: adds register writeback, RS2/immediate operand select, a full op set, and multiply.

Parameters:
NBITS, 8, data/register width (>=4)
NREGS, 32, register count; register 0 reads as zero
WIDTH_ALUF, 4, ALUControl width

Ports:
clock  in  1  single clock
reset  in  1  synchronous, active-high
RS1, RS2, RD  in  $clog2(NREGS)  register indices
IMM  in  NBITS signed  immediate
ALUControl  in  WIDTH_ALUF  op code (datapath_pkg)
ALUSrc  in  1  1: SrcB=IMM, 0: SrcB=reg[RS2]
MemtoReg  in  1  Result=ReadData
RegWrite  in  1  write Result to RD
link  in  1  Result=pclink (highest priority)
pclink  in  NBITS  PC value for link
MulStart  in  1  start multiply reg[RS1]*reg[RS2] into RD
MulHigh  in  1  sampled with MulStart; 1 selects the high NBITS of the unsigned product
Zero, Neg, Carry  out  1 each  compare flags
PCReg  out  NBITS  SrcA, returned to the PC
Address  out  NBITS-2 (bits NBITS-1:2)  ALUResult[NBITS-1:2]
WriteData  out  NBITS  reg[RS2]
ReadData  in  NBITS  memory read data
Busy  out  1  multiplier not idle
Stall  out  1  controller must hold PC and instruction

Behaviour:
- Reset (synchronous, active-high): all registers 0; multiplier goes to IDLE; Busy=0; Stall=0. Reset mid-multiply aborts it with no writeback.
- Reads are combinational. No write bypass: a read in the same cycle as a write to that register returns the old value.
- Register 0 always reads 0. Writes to it are discarded.
- SrcA=reg[RS1]. SrcB = ALUSrc ? IMM : reg[RS2].
- ALU ops: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5 (signed, result 0/1), SLTU 6, SLL 7, SRL 8, SRA 9. Undefined codes perform ADD.
- Shift amount is SrcB[$clog2(NBITS)-1:0].
- Flags always come from D=SrcA+~SrcB+1 computed at NBITS+1 bits, independent of ALUControl:
  - Zero = (D[NBITS-1:0]==0)
  - Neg = signed(SrcA) < signed(SrcB)
  - Carry = D[NBITS], i.e. 1 when SrcA >= SrcB unsigned.
- Result mux: link ? pclink : MemtoReg ? ReadData : ALUResult.
- Normal write: at posedge when RegWrite && !Stall && RD!=0.
- Multiplier FSM:
  - States IDLE, RUN, WB.
  - IDLE + MulStart: latch A=reg[RS1], B=reg[RS2], RD and MulHigh; clear the 2*NBITS accumulator; set counter to NBITS-1; go to RUN.
  - RUN: each cycle, if B[0] add A<<k into the accumulator, then shift B right. When the counter reaches 0, go to WB.
  - WB: write the accumulator low or high half to the latched RD (unless RD==0); go to IDLE.
- Stall = MulStart || state!=IDLE, combinational. Busy = state!=IDLE.
- While Stall=1, RegWrite is ignored.
- MulStart while Busy is ignored and does not restart the operation.
- Latency: MulStart in cycle t; writeback at the end of cycle t+NBITS+1; Stall is low from cycle t+NBITS+2. The new RD value is readable then.
- Operands are latched, so RS1/RS2 may change during RUN without effect.

Decomposition:
- datapath_pkg: alu_op_t enum (codes above), mul_state_t {IDLE, RUN, WB}, ALU_DEFAULT=ADD.
- One sub-module: mul_iter.
  - Parameter NBITS.
  - Ports: clock, reset, start, a, b, high, busy, done, p.
  - done is a 1-cycle pulse in WB.
- The datapath owns the register file, ALU, the write-port arbitration and the latched RD.

Test Plan:
- Reset, then read every register index -> all read 0; Stall=0, Busy=0. Write 8'hFF to reg0 -> reads 0.
- NBITS=8: reg1=8'd5, reg2=8'd7, SUB with ALUSrc=0 -> ALUResult=8'hFE, Neg=1, Carry=0, Zero=0. Swap operands -> ALUResult=8'h02, Neg=0, Carry=1.
- reg1=8'h80, IMM=3: SRA -> 8'hF0; SRL -> 8'h10; SLT vs reg0 -> 1; SLTU vs reg0 -> 0. ALUControl=4'hF -> 8'h83.
- reg1=8'd200, reg2=8'd3, MulStart, RD=4, MulHigh=0 -> Stall high 10 cycles; reg4=8'h58. Repeat with MulHigh=1 -> reg4=8'h02.
- During RUN: assert RegWrite and a second MulStart -> neither takes effect; only the first result lands.
- Reset asserted on RUN cycle 3 -> no write to RD; Busy=0 next cycle. link=1, pclink=8'h24, RD=1 -> reg1=8'h24. Address equals ALUResult[7:2].

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared types for the multi-cycle datapath.
//   alu_op_t    : ALUControl encodings (codes not listed here execute ADD)
//   mul_state_t : iterative multiplier states
package datapath_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } mul_state_t;

  localparam alu_op_t ALU_DEFAULT = ALU_ADD;

endpackage

// File: rtl/datapath_mc_if.sv
// Controller/memory-facing bundle of the multi-cycle datapath.
//   master : controller side (drives decoded fields and control, ReadData)
//   slave  : datapath side (drives flags, PCReg, Address, WriteData, Busy, Stall)
interface datapath_mc_if #(
  parameter int NBITS      = 8,
  parameter int NREGS      = 32,
  parameter int WIDTH_ALUF = 4
);
  localparam int RW = $clog2(NREGS);

  logic [RW-1:0]         RS1, RS2, RD;
  logic [NBITS-1:0]      IMM;
  logic [WIDTH_ALUF-1:0] ALUControl;
  logic                  ALUSrc, MemtoReg, RegWrite, link;
  logic [NBITS-1:0]      pclink;
  logic                  MulStart, MulHigh;
  logic                  Zero, Neg, Carry;
  logic [NBITS-1:0]      PCReg;
  logic [NBITS-3:0]      Address;
  logic [NBITS-1:0]      WriteData;
  logic [NBITS-1:0]      ReadData;
  logic                  Busy, Stall;

  modport master (
    output RS1, RS2, RD, IMM, ALUControl, ALUSrc, MemtoReg, RegWrite,
           link, pclink, MulStart, MulHigh, ReadData,
    input  Zero, Neg, Carry, PCReg, Address, WriteData, Busy, Stall
  );

  modport slave (
    input  RS1, RS2, RD, IMM, ALUControl, ALUSrc, MemtoReg, RegWrite,
           link, pclink, MulStart, MulHigh, ReadData,
    output Zero, Neg, Carry, PCReg, Address, WriteData, Busy, Stall
  );
endinterface

// File: rtl/datapath_mc_mul.sv
// Iterative shift-add unsigned multiplier (one partial product per cycle).
//   clock, reset : clock, synchronous active-high reset (aborts any operation)
//   start        : accepted only when idle; latches a, b and high
//   busy         : state != IDLE
//   done         : one-cycle pulse while in WB, p is final then
//   p            : low or high NBITS of a*b, chosen by the latched high
module mul_iter
  import datapath_pkg::*;
#(
  parameter int NBITS = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  input  logic             high,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] p
);
  localparam int CW = $clog2(NBITS);

  mul_state_t         state, state_nx;
  logic [2*NBITS-1:0] acc, a_sh;
  logic [NBITS-1:0]   b_sh;
  logic [CW-1:0]      cnt;
  logic               high_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      cnt    <= '0;
      high_q <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          a_sh   <= (2*NBITS)'(a);
          b_sh   <= b;
          acc    <= '0;
          cnt    <= CW'(NBITS-1);
          high_q <= high;
        end
        RUN: begin
          // a_sh holds A<<k for iteration k; b_sh[0] is bit k of B
          if (b_sh[0]) acc <= acc + a_sh;
          a_sh <= a_sh << 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (cnt == '0) state_nx = WB;
      WB:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == WB);
  assign p    = high_q ? acc[2*NBITS-1:NBITS] : acc[NBITS-1:0];

endmodule

// File: rtl/datapath_mc.sv
// Multi-cycle datapath: 2-read/1-write register file (reg 0 hard zero),
// ALU with subtraction-based compare flags, result/writeback mux and an
// iterative multiplier that stalls the controller until its writeback.
//   clock, reset : clock, synchronous active-high reset
//   bus (slave)  : decoded fields/control in; flags, PCReg, Address,
//                  WriteData, Busy, Stall out; ReadData from memory
module datapath_mc
  import datapath_pkg::*;
#(
  parameter int NBITS      = 8,
  parameter int NREGS      = 32,
  parameter int WIDTH_ALUF = 4
) (
  input  logic          clock,
  input  logic          reset,
  datapath_mc_if.slave  bus
);
  localparam int RW = $clog2(NREGS);
  localparam int SW = $clog2(NBITS);

  logic [NBITS-1:0] regs [NREGS];
  logic [NBITS-1:0] src_a, src_b, rd2, alu_res, result;
  logic [NBITS:0]   diff;
  logic [SW-1:0]    shamt;
  logic [31:0]      op;

  logic             mul_busy, mul_done;
  logic [NBITS-1:0] mul_p;
  logic [RW-1:0]    mul_rd;

  logic             we;
  logic [RW-1:0]    wa;
  logic [NBITS-1:0] wd;

  // Reads are combinational with no bypass from the write port
  assign src_a = (bus.RS1 == '0) ? '0 : regs[bus.RS1];
  assign rd2   = (bus.RS2 == '0) ? '0 : regs[bus.RS2];
  assign src_b = bus.ALUSrc ? bus.IMM : rd2;
  assign shamt = src_b[SW-1:0];
  assign op    = 32'(bus.ALUControl);

  always_comb begin
    alu_res = src_a + src_b;
    case (op)
      32'(ALU_SUB):  alu_res = src_a - src_b;
      32'(ALU_AND):  alu_res = src_a & src_b;
      32'(ALU_OR):   alu_res = src_a | src_b;
      32'(ALU_XOR):  alu_res = src_a ^ src_b;
      32'(ALU_SLT):  alu_res = {{(NBITS-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      32'(ALU_SLTU): alu_res = {{(NBITS-1){1'b0}}, (src_a < src_b)};
      32'(ALU_SLL):  alu_res = src_a << shamt;
      32'(ALU_SRL):  alu_res = src_a >> shamt;
      32'(ALU_SRA):  alu_res = NBITS'($signed(src_a) >>> shamt);
      default:       alu_res = src_a + src_b;
    endcase
  end

  // Flags always reflect SrcA-SrcB regardless of the selected op
  assign diff      = {1'b0, src_a} + {1'b0, ~src_b} + (NBITS+1)'(1);
  assign bus.Zero  = (diff[NBITS-1:0] == '0);
  assign bus.Neg   = ($signed(src_a) < $signed(src_b));
  assign bus.Carry = diff[NBITS];

  assign result = bus.link ? bus.pclink : (bus.MemtoReg ? bus.ReadData : alu_res);

  assign bus.PCReg     = src_a;
  assign bus.Address   = alu_res[NBITS-1:2];
  assign bus.WriteData = rd2;
  assign bus.Busy      = mul_busy;
  assign bus.Stall     = bus.MulStart | mul_busy;

  mul_iter #(.NBITS(NBITS)) u_mul (
    .clock (clock),
    .reset (reset),
    .start (bus.MulStart),
    .a     (src_a),
    .b     (rd2),
    .high  (bus.MulHigh),
    .busy  (mul_busy),
    .done  (mul_done),
    .p     (mul_p)
  );

  always_ff @(posedge clock) begin
    if (reset) mul_rd <= '0;
    else if (bus.MulStart && !mul_busy) mul_rd <= bus.RD;
  end

  // Multiplier writeback only happens while Stall is high, so it never
  // competes with a normal write in the same cycle.
  always_comb begin
    we = 1'b0;
    wa = '0;
    wd = '0;
    if (mul_done) begin
      we = (mul_rd != '0);
      wa = mul_rd;
      wd = mul_p;
    end else if (bus.RegWrite && !bus.Stall && bus.RD != '0) begin
      we = 1'b1;
      wa = bus.RD;
      wd = result;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

endmodule

// File: tb/tb_datapath_mc.sv
module tb_datapath_mc;
  import datapath_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  datapath_mc_if #(.NBITS(8), .NREGS(32), .WIDTH_ALUF(4)) bus ();

  datapath_mc #(.NBITS(8), .NREGS(32), .WIDTH_ALUF(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0] rs1, rs2;
    logic [7:0] imm;
    logic [3:0] op;
    logic       alusrc;
    logic [7:0] res;
    logic       z, n, c;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.RS1 = '0; bus.RS2 = '0; bus.RD = '0; bus.IMM = '0;
    bus.ALUControl = 4'(ALU_ADD); bus.ALUSrc = 1'b0; bus.MemtoReg = 1'b0;
    bus.RegWrite = 1'b0; bus.link = 1'b0; bus.pclink = '0;
    bus.MulStart = 1'b0; bus.MulHigh = 1'b0; bus.ReadData = '0;
  endtask

  task automatic write_reg(input logic [4:0] idx, input logic [7:0] val);
    @(negedge clock);
    idle_inputs();
    bus.ALUSrc = 1'b1; bus.IMM = val; bus.RD = idx; bus.RegWrite = 1'b1;
    @(negedge clock);
    bus.RegWrite = 1'b0;
  endtask

  task automatic read_reg(input logic [4:0] idx, output logic [7:0] val);
    bus.RS1 = idx;
    #1 val = bus.PCReg;
  endtask

  // Returns number of cycles Stall was observed high, starting at MulStart
  task automatic run_mul(input logic [4:0] rd, input logic high, input logic disturb,
                         output int cyc);
    cyc = 0;
    @(negedge clock);
    idle_inputs();
    bus.RS1 = 5'd1; bus.RS2 = 5'd2; bus.RD = rd; bus.MulHigh = high; bus.MulStart = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!bus.Stall) break;
      cyc++;
      @(negedge clock);
      bus.MulStart = 1'b0;
      bus.RegWrite = 1'b0;
      if (disturb && i == 0) begin
        // second start plus a normal write, both while busy
        bus.MulStart = 1'b1; bus.RS1 = 5'd2; bus.RS2 = 5'd2; bus.RD = 5'd6;
        bus.ALUSrc = 1'b1; bus.IMM = 8'h11; bus.RegWrite = 1'b1;
      end else if (i == 2) begin
        bus.RS1 = 5'd3; bus.RS2 = 5'd3;
      end
    end
    bus.RegWrite = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    int cyc;

    //          rs1   rs2   imm    op  src  res   z n c
    vecs[0]  = '{5'd1, 5'd2, 8'h00, 4'd1, 1'b0, 8'hFE, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{5'd2, 5'd1, 8'h00, 4'd1, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{5'd1, 5'd1, 8'h00, 4'd1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{5'd1, 5'd2, 8'h00, 4'd0, 1'b0, 8'h0C, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{5'd1, 5'd0, 8'h0C, 4'd2, 1'b1, 8'h04, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{5'd1, 5'd0, 8'h0A, 4'd3, 1'b1, 8'h0F, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{5'd2, 5'd1, 8'h00, 4'd4, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{5'd1, 5'd0, 8'h03, 4'd7, 1'b1, 8'h28, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{5'd3, 5'd0, 8'h03, 4'd9, 1'b1, 8'hF0, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{5'd3, 5'd0, 8'h03, 4'd8, 1'b1, 8'h10, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{5'd3, 5'd0, 8'h00, 4'd5, 1'b0, 8'h01, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{5'd3, 5'd0, 8'h00, 4'd6, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{5'd3, 5'd0, 8'h03, 4'hF, 1'b1, 8'h83, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{5'd1, 5'd0, 8'h09, 4'd7, 1'b1, 8'h0A, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{5'd1, 5'd3, 8'h00, 4'd5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{5'd1, 5'd3, 8'h00, 4'd6, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0};

    idle_inputs();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    check("reset_stall", 32'(bus.Stall), 32'd0);
    check("reset_busy", 32'(bus.Busy), 32'd0);
    for (int i = 0; i < 32; i++) begin
      read_reg(5'(i), v);
      check($sformatf("reset_reg%0d", i), 32'(v), 32'h00);
    end

    write_reg(5'd0, 8'hFF);
    read_reg(5'd0, v);
    check("reg0_write_discarded", 32'(v), 32'h00);

    write_reg(5'd1, 8'd5);
    write_reg(5'd2, 8'd7);
    write_reg(5'd3, 8'h80);

    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      idle_inputs();
      bus.RS1 = vecs[i].rs1; bus.RS2 = vecs[i].rs2; bus.IMM = vecs[i].imm;
      bus.ALUControl = vecs[i].op; bus.ALUSrc = vecs[i].alusrc;
      bus.RD = 5'd10; bus.RegWrite = 1'b1;
      #1;
      check($sformatf("v%0d_zero", i), 32'(bus.Zero), 32'(vecs[i].z));
      check($sformatf("v%0d_neg", i), 32'(bus.Neg), 32'(vecs[i].n));
      check($sformatf("v%0d_carry", i), 32'(bus.Carry), 32'(vecs[i].c));
      check($sformatf("v%0d_addr", i), 32'(bus.Address), 32'(vecs[i].res[7:2]));
      @(negedge clock);
      bus.RegWrite = 1'b0;
      read_reg(5'd10, v);
      check($sformatf("v%0d_result", i), 32'(v), 32'(vecs[i].res));
    end

    // no write bypass: same-cycle read of the written register sees old data
    write_reg(5'd9, 8'h11);
    @(negedge clock);
    idle_inputs();
    bus.RS2 = 5'd9; bus.ALUSrc = 1'b1; bus.IMM = 8'h22; bus.RD = 5'd9; bus.RegWrite = 1'b1;
    #1 check("no_bypass_old", 32'(bus.WriteData), 32'h11);
    @(negedge clock);
    bus.RegWrite = 1'b0;
    #1 check("no_bypass_new", 32'(bus.WriteData), 32'h22);

    // memory load path
    @(negedge clock);
    idle_inputs();
    bus.MemtoReg = 1'b1; bus.ReadData = 8'h3C; bus.RD = 5'd8; bus.RegWrite = 1'b1;
    @(negedge clock);
    bus.RegWrite = 1'b0;
    read_reg(5'd8, v);
    check("memtoreg", 32'(v), 32'h3C);

    // multiply 200*3 = 0x0258
    write_reg(5'd1, 8'd200);
    write_reg(5'd2, 8'd3);
    run_mul(5'd4, 1'b0, 1'b0, cyc);
    check("mul_lo_stall_cycles", 32'(cyc), 32'd10);
    read_reg(5'd4, v);
    check("mul_lo_result", 32'(v), 32'h58);

    run_mul(5'd4, 1'b1, 1'b0, cyc);
    check("mul_hi_stall_cycles", 32'(cyc), 32'd10);
    read_reg(5'd4, v);
    check("mul_hi_result", 32'(v), 32'h02);

    run_mul(5'd5, 1'b0, 1'b1, cyc);
    check("mul_disturb_stall_cycles", 32'(cyc), 32'd10);
    read_reg(5'd5, v);
    check("mul_disturb_result", 32'(v), 32'h58);
    read_reg(5'd6, v);
    check("mul_disturb_reg6_untouched", 32'(v), 32'h00);

    // reset during RUN cycle 3 aborts the multiply
    @(negedge clock);
    idle_inputs();
    bus.RS1 = 5'd1; bus.RS2 = 5'd2; bus.RD = 5'd7; bus.MulStart = 1'b1;
    @(negedge clock);
    bus.MulStart = 1'b0;
    #1 check("abort_busy_in_run", 32'(bus.Busy), 32'd1);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort_busy", 32'(bus.Busy), 32'd0);
    check("abort_stall", 32'(bus.Stall), 32'd0);
    repeat (12) @(negedge clock);
    check("abort_busy_later", 32'(bus.Busy), 32'd0);
    read_reg(5'd7, v);
    check("abort_no_write", 32'(v), 32'h00);

    // link has priority over memory and ALU results
    @(negedge clock);
    idle_inputs();
    bus.link = 1'b1; bus.pclink = 8'h24; bus.MemtoReg = 1'b1; bus.ReadData = 8'h99;
    bus.ALUSrc = 1'b1; bus.IMM = 8'h5C; bus.RD = 5'd1; bus.RegWrite = 1'b1;
    #1 check("link_address", 32'(bus.Address), 32'h17);
    @(negedge clock);
    bus.RegWrite = 1'b0; bus.link = 1'b0; bus.MemtoReg = 1'b0;
    read_reg(5'd1, v);
    check("link_result", 32'(v), 32'h24);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
